// File: rtl/timestamp_wr_sched_if.sv
// rtl/timestamp_wr_sched_if.sv - request, bank-write and flush bundle for timestamp_wr_sched
interface timestamp_wr_sched_if #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int INPUTS     = 4,
  parameter int TIME_BITS  = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
  logic [0:INPUTS-1]     req_valid;
  logic [ADDR_WIDTH-1:0] req_addr [0:INPUTS-1];
  logic [WIDTH-1:0]      req_data [0:INPUTS-1];
  logic [0:INPUTS-1]     req_ready;
  logic [0:INPUTS-1]     wr;
  logic [ADDR_WIDTH-1:0] wr_addr [0:INPUTS-1];
  logic [WIDTH-1:0]      wr_data [0:INPUTS-1];
  logic [TIME_BITS-1:0]  wr_time;
  logic                  flush_req;
  logic                  flush_done;

  // Requesters and the resolution logic side
  modport master (
    output req_valid, req_addr, req_data, flush_done,
    input  req_ready, wr, wr_addr, wr_data, wr_time, flush_req
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_addr, req_data, flush_done,
    output req_ready, wr, wr_addr, wr_data, wr_time, flush_req
  );
endinterface

// File: rtl/timestamp_wr_sched.sv
// rtl/timestamp_wr_sched.sv - write scheduler: same-address round-robin, timestamping, wrap flush
module timestamp_wr_sched #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int INPUTS     = 4,
  parameter int TIME_BITS  = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int PORT_BITS  = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  timestamp_wr_sched_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, RESTART} state_e;

  state_e                state_q, state_d;
  logic [TIME_BITS-1:0]  now_q, now_d;
  logic [PORT_BITS-1:0]  rr_q, rr_d;
  logic                  flush_req_q, flush_req_d;
  logic [0:INPUTS-1]     wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q [0:INPUTS-1];
  logic [ADDR_WIDTH-1:0] wr_addr_d [0:INPUTS-1];
  logic [WIDTH-1:0]      wr_data_q [0:INPUTS-1];
  logic [WIDTH-1:0]      wr_data_d [0:INPUTS-1];
  logic [TIME_BITS-1:0]  wr_time_q, wr_time_d;

  logic [0:INPUTS-1]     beaten;
  logic [0:INPUTS-1]     collide;
  logic [0:INPUTS-1]     grant;
  logic [PORT_BITS-1:0]  rr_next;
  logic                  lo_found;
  logic                  win_found;
  logic [ADDR_WIDTH-1:0] lo_addr;

  // Distance of port k from the round-robin pointer in scan order
  function automatic int scan_pos(input int k, input logic [PORT_BITS-1:0] rr);
    return (k >= int'(rr)) ? (k - int'(rr)) : (k - int'(rr) + INPUTS);
  endfunction

  // Grant one port per address group: the member closest to rr_q in scan order
  always_comb begin
    beaten  = '0;
    collide = '0;
    for (int i = 0; i < INPUTS; i++) begin
      for (int j = 0; j < INPUTS; j++) begin
        if (i != j && bus.req_valid[i] && bus.req_valid[j] &&
            bus.req_addr[i] == bus.req_addr[j]) begin
          collide[i] = 1'b1;
          if (scan_pos(j, rr_q) < scan_pos(i, rr_q)) beaten[i] = 1'b1;
        end
      end
    end
    grant = (state_q == RUN && !rst) ? (bus.req_valid & ~beaten) : '0;
  end

  // Pointer moves past the winner of the group holding the lowest-index colliding port
  always_comb begin
    lo_found  = 1'b0;
    lo_addr   = '0;
    win_found = 1'b0;
    rr_next   = rr_q;
    for (int i = 0; i < INPUTS; i++) begin
      if (!lo_found && collide[i]) begin
        lo_found = 1'b1;
        lo_addr  = bus.req_addr[i];
      end
    end
    for (int j = 0; j < INPUTS; j++) begin
      if (lo_found && !win_found && grant[j] && bus.req_addr[j] == lo_addr) begin
        win_found = 1'b1;
        rr_next   = PORT_BITS'((j + 1) % INPUTS);
      end
    end
  end

  // Next-state: issue granted writes, advance the clock, run the wrap flush sequence
  always_comb begin
    state_d     = state_q;
    now_d       = now_q;
    rr_d        = rr_q;
    flush_req_d = flush_req_q;
    wr_d        = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_time_d   = wr_time_q;
    case (state_q)
      RUN: begin
        if (|grant) begin
          wr_d      = grant;
          wr_time_d = now_q;
          rr_d      = rr_next;
          for (int i = 0; i < INPUTS; i++) begin
            if (grant[i]) begin
              wr_addr_d[i] = bus.req_addr[i];
              wr_data_d[i] = bus.req_data[i];
            end
          end
          // The max stamp is used once; the counter then waits for the flush
          if (now_q == {TIME_BITS{1'b1}}) state_d = DRAIN;
          else                            now_d   = now_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d     = FLUSH;
        flush_req_d = 1'b1;
      end
      FLUSH: begin
        if (bus.flush_done) state_d = RESTART;
      end
      RESTART: begin
        flush_req_d = 1'b0;
        now_d       = TIME_BITS'(1);
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers; 0 is reserved as the "never written" stamp
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      now_q       <= TIME_BITS'(1);
      rr_q        <= '0;
      flush_req_q <= 1'b0;
      wr_q        <= '0;
      wr_addr_q   <= '{default: '0};
      wr_data_q   <= '{default: '0};
      wr_time_q   <= '0;
    end else begin
      state_q     <= state_d;
      now_q       <= now_d;
      rr_q        <= rr_d;
      flush_req_q <= flush_req_d;
      wr_q        <= wr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_time_q   <= wr_time_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.wr        = wr_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_time   = wr_time_q;
  assign bus.flush_req = flush_req_q;

endmodule

// File: tb/tb_timestamp_wr_sched.sv
// tb/tb_timestamp_wr_sched.sv - scoreboard bench for timestamp_wr_sched
module tb_timestamp_wr_sched;
  localparam int WIDTH      = 64;
  localparam int DEPTH      = 512;
  localparam int INPUTS     = 4;
  localparam int TIME_BITS  = 4;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int QSZ        = 32;
  localparam int TMAX       = (1 << TIME_BITS) - 1;

  typedef enum {M_RUN, M_DRAIN, M_FLUSH, M_RESTART} mstate_e;

  typedef struct {
    logic [0:INPUTS-1]                 vec;
    logic [0:INPUTS-1][ADDR_WIDTH-1:0] addr;
    logic [0:INPUTS-1][WIDTH-1:0]      data;
    logic [TIME_BITS-1:0]              t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timestamp_wr_sched_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INPUTS(INPUTS), .TIME_BITS(TIME_BITS)) bus ();

  timestamp_wr_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INPUTS(INPUTS), .TIME_BITS(TIME_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t sb [$];

  logic [ADDR_WIDTH-1:0] pq_addr [INPUTS][QSZ];
  logic [WIDTH-1:0]      pq_data [INPUTS][QSZ];
  int                    head [INPUTS];
  int                    tail [INPUTS];
  logic [0:INPUTS-1]     xfer;

  mstate_e m_state;
  int      m_now;
  int      m_rr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input int p, input int a, input logic [WIDTH-1:0] d);
    pq_addr[p][tail[p]] = ADDR_WIDTH'(a);
    pq_data[p][tail[p]] = d;
    tail[p]++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < INPUTS; i++) begin
      if (head[i] < tail[i]) begin
        bus.req_valid[i] = 1'b1;
        bus.req_addr[i]  = pq_addr[i][head[i]];
        bus.req_data[i]  = pq_data[i][head[i]];
      end else begin
        bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  // Reference arbitration: per port, find its address group's first valid member from m_rr
  function automatic logic [0:INPUTS-1] model_grant();
    logic [0:INPUTS-1] g;
    g = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (bus.req_valid[i]) begin
        int win;
        win = -1;
        for (int k = 0; k < INPUTS; k++) begin
          int p;
          p = (m_rr + k) % INPUTS;
          if (win < 0 && bus.req_valid[p] && bus.req_addr[p] == bus.req_addr[i]) win = p;
        end
        if (win == i) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic int model_rr();
    int lo;
    int win;
    lo  = -1;
    win = -1;
    for (int i = 0; i < INPUTS; i++)
      for (int j = 0; j < INPUTS; j++)
        if (lo < 0 && i != j && bus.req_valid[i] && bus.req_valid[j] &&
            bus.req_addr[i] == bus.req_addr[j]) lo = i;
    if (lo < 0) return m_rr;
    for (int k = 0; k < INPUTS; k++) begin
      int p;
      p = (m_rr + k) % INPUTS;
      if (win < 0 && bus.req_valid[p] && bus.req_addr[p] == bus.req_addr[lo]) win = p;
    end
    return (win + 1) % INPUTS;
  endfunction

  task automatic monitor();
    logic [0:INPUTS-1] g;
    exp_t e;
    if (bus.wr !== '0 || sb.size() != 0) begin
      if (sb.size() == 0) begin
        check_eq("wr_unexpected", 64'(bus.wr), 64'(0));
      end else begin
        e = sb.pop_front();
        check_eq("wr_vec", 64'(bus.wr), 64'(e.vec));
        check_eq("wr_time", 64'(bus.wr_time), 64'(e.t));
        for (int i = 0; i < INPUTS; i++) begin
          if (e.vec[i]) begin
            check_eq($sformatf("wr_addr%0d", i), 64'(bus.wr_addr[i]), 64'(e.addr[i]));
            check_eq($sformatf("wr_data%0d", i), 64'(bus.wr_data[i]), 64'(e.data[i]));
          end
        end
      end
    end
    check_eq("flush_req", 64'(bus.flush_req), 64'(m_state == M_FLUSH || m_state == M_RESTART));
    g = (rst || m_state != M_RUN) ? '0 : model_grant();
    check_eq("req_ready", 64'(bus.req_ready), 64'(g));
    xfer = bus.req_valid & bus.req_ready;
    if (rst) begin
      m_state = M_RUN;
      m_now   = 1;
      m_rr    = 0;
    end else begin
      case (m_state)
        M_RUN: begin
          if (g != '0) begin
            e.vec = g;
            e.t   = TIME_BITS'(m_now);
            for (int i = 0; i < INPUTS; i++) begin
              e.addr[i] = bus.req_addr[i];
              e.data[i] = bus.req_data[i];
            end
            sb.push_back(e);
            m_rr = model_rr();
            if (m_now == TMAX) m_state = M_DRAIN;
            else               m_now++;
          end
        end
        M_DRAIN:   m_state = M_FLUSH;
        M_FLUSH:   if (bus.flush_done) m_state = M_RESTART;
        M_RESTART: begin
          m_now   = 1;
          m_state = M_RUN;
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < INPUTS; i++) if (xfer[i]) head[i]++;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < INPUTS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_inputs();
    step();
    step();
    check_eq("rst_wr", 64'(bus.wr), 64'(0));
    check_eq("rst_wr_time", 64'(bus.wr_time), 64'(0));
    check_eq("rst_flush_req", 64'(bus.flush_req), 64'(0));
    for (int i = 0; i < INPUTS; i++) begin
      check_eq("rst_wr_addr", 64'(bus.wr_addr[i]), 64'(0));
      check_eq("rst_wr_data", 64'(bus.wr_data[i]), 64'(0));
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.flush_done = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      bus.req_addr[i] = '0;
      bus.req_data[i] = '0;
      head[i] = 0;
      tail[i] = 0;
    end
    m_state = M_RUN;
    m_now   = 1;
    m_rr    = 0;
    xfer    = '0;

    // Single write, then a second stamped one higher
    do_reset();
    push_req(0, 5, 64'hAB);
    drive_inputs();
    step();
    check_eq("single_wr", 64'(bus.wr), 64'b1000);
    check_eq("single_addr", 64'(bus.wr_addr[0]), 64'd5);
    check_eq("single_data", 64'(bus.wr_data[0]), 64'hAB);
    check_eq("single_time", 64'(bus.wr_time), 64'd1);
    push_req(0, 6, 64'hCD);
    drive_inputs();
    step();
    check_eq("second_time", 64'(bus.wr_time), 64'd2);
    step();

    // Four distinct addresses in one cycle
    do_reset();
    for (int i = 0; i < INPUTS; i++) push_req(i, i + 1, 64'h100 + 64'(i));
    drive_inputs();
    step();
    check_eq("distinct_wr", 64'(bus.wr), 64'b1111);
    check_eq("distinct_time", 64'(bus.wr_time), 64'd1);
    step();

    // Collision of ports 1 and 3
    do_reset();
    push_req(1, 7, 64'h11);
    push_req(3, 7, 64'h33);
    drive_inputs();
    step();
    check_eq("coll_first", 64'(bus.wr), 64'b0100);
    check_eq("coll_first_time", 64'(bus.wr_time), 64'd1);
    step();
    check_eq("coll_second", 64'(bus.wr), 64'b0001);
    check_eq("coll_second_time", 64'(bus.wr_time), 64'd2);
    step();

    // All four ports on one address
    do_reset();
    for (int i = 0; i < INPUTS; i++) push_req(i, 9, 64'h900 + 64'(i));
    drive_inputs();
    for (int k = 0; k < INPUTS; k++) begin
      logic [0:INPUTS-1] one;
      one = '0;
      one[k] = 1'b1;
      step();
      check_eq("rr_order", 64'(bus.wr), 64'(one));
      check_eq("rr_time", 64'(bus.wr_time), 64'(k + 1));
    end
    step();

    // Wrap: 15 writes, drain, long flush, restart
    do_reset();
    for (int k = 0; k < TMAX; k++) push_req(0, k, 64'($urandom));
    drive_inputs();
    for (int k = 0; k < TMAX; k++) step();
    check_eq("wrap_last_time", 64'(bus.wr_time), 64'(TMAX));
    push_req(0, 100, 64'hBEEF);
    drive_inputs();
    step();
    check_eq("wrap_flush_req", 64'(bus.flush_req), 64'd1);
    for (int k = 0; k < 5; k++) step();
    check_eq("wrap_flush_hold", 64'(bus.flush_req), 64'd1);
    check_eq("wrap_ready_hold", 64'(bus.req_ready), 64'd0);
    bus.flush_done = 1'b1;
    step();
    bus.flush_done = 1'b0;
    step();
    step();
    check_eq("wrap_restart_wr", 64'(bus.wr), 64'b1000);
    check_eq("wrap_restart_time", 64'(bus.wr_time), 64'd1);
    step();

    // Reset while in FLUSH
    do_reset();
    for (int k = 0; k < TMAX; k++) push_req(2, k, 64'($urandom));
    drive_inputs();
    for (int k = 0; k < TMAX; k++) step();
    step();
    step();
    check_eq("pre_rst_flush_req", 64'(bus.flush_req), 64'd1);
    rst = 1'b1;
    step();
    check_eq("rst_flush_drop", 64'(bus.flush_req), 64'd0);
    rst = 1'b0;
    bus.flush_done = 1'b1;
    push_req(0, 42, 64'h4242);
    drive_inputs();
    step();
    check_eq("post_rst_wr", 64'(bus.wr), 64'b1000);
    check_eq("post_rst_time", 64'(bus.wr_time), 64'd1);
    check_eq("post_rst_flush_req", 64'(bus.flush_req), 64'd0);
    step();
    bus.flush_done = 1'b0;
    step();
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
